// File: rtl/de10_bus_pkg.sv
// Shared constants for the DE10-Lite bus request/response controller:
// region tags, state encoding and default widths.
package de10_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned TAG_W      = 10;
    localparam int unsigned TMO_CNT_W  = 8;

    localparam logic [TAG_W-1:0] TAG_SDRAM  = 10'h0;
    localparam logic [TAG_W-1:0] TAG_PERIPH = 10'h1;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE        = 3'd0,
        S_WAIT_SDRAM  = 3'd1,
        S_WAIT_PERIPH = 3'd2,
        S_RESP        = 3'd3,
        S_ERR         = 3'd4
    } state_e;

endpackage

// File: rtl/de10_bus_resp_ctrl_timeout_ctr.sv
// Wait-cycle counter: flags the cycle whose un-acked edge would reach LIMIT.
module de10_bus_timeout_ctr
    import de10_bus_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    // Combinational so the FSM can abort on the very edge the limit is reached.
    assign expired_c = enable_i && (cnt_q == TMO_CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + TMO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/de10_bus_resp_ctrl.sv
// CPU data-port controller for the SDRAM and peripheral targets.
// Optional hung-target abort is enabled with `define DE10_BUS_TIMEOUT_EN.
module de10_bus_resp_ctrl
    import de10_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic              sdram_sel,
    output logic              periph_sel,
    output logic              tgt_we,
    output logic [ADDR_W-1:0] tgt_addr,
    output logic [DATA_W-1:0] tgt_wdata,
    input  logic              sdram_ack,
    input  logic              periph_ack,
    input  logic [DATA_W-1:0] sdram_rdata,
    input  logic [DATA_W-1:0] periph_rdata
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              sdram_sel_q, sdram_sel_d;
    logic              periph_sel_q, periph_sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TAG_W-1:0]  tag_c;
    logic              timeout_c;

    assign tag_c = cpu_addr[ADDR_W-1 -: TAG_W];

`ifdef DE10_BUS_TIMEOUT_EN
    logic wait_c;
    logic ack_c;

    assign wait_c = (state_q == S_WAIT_SDRAM) || (state_q == S_WAIT_PERIPH);
    assign ack_c  = ((state_q == S_WAIT_SDRAM) && sdram_ack) ||
                    ((state_q == S_WAIT_PERIPH) && periph_ack);

    de10_bus_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!wait_c),
        .enable_i  (wait_c && !ack_c),
        .expired_c (timeout_c)
    );
`else
    logic unused_timeout_c;

    assign unused_timeout_c = ^TIMEOUT_CYCLES;
    assign timeout_c        = 1'b0;
`endif

    // Next state and next registered outputs; selects and pulses default low.
    always_comb begin
        state_d      = state_q;
        rdata_d      = '0;
        ready_d      = 1'b0;
        err_d        = 1'b0;
        sdram_sel_d  = 1'b0;
        periph_sel_d = 1'b0;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    if (tag_c == TAG_SDRAM) begin
                        state_d     = S_WAIT_SDRAM;
                        sdram_sel_d = 1'b1;
                    end else if (tag_c == TAG_PERIPH) begin
                        state_d      = S_WAIT_PERIPH;
                        periph_sel_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_WAIT_SDRAM: begin
                if (sdram_ack) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    rdata_d = we_q ? '0 : sdram_rdata;
                end else if (timeout_c) begin
                    state_d = S_ERR;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    sdram_sel_d = 1'b1;
                end
            end
            S_WAIT_PERIPH: begin
                if (periph_ack) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    rdata_d = we_q ? '0 : periph_rdata;
                end else if (timeout_c) begin
                    state_d = S_ERR;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    periph_sel_d = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            sdram_sel_q  <= 1'b0;
            periph_sel_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            sdram_sel_q  <= sdram_sel_d;
            periph_sel_q <= periph_sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_ready  = ready_q;
    assign cpu_err    = err_q;
    assign sdram_sel  = sdram_sel_q;
    assign periph_sel = periph_sel_q;
    assign tgt_we     = we_q;
    assign tgt_addr   = addr_q;
    assign tgt_wdata  = wdata_q;

endmodule

// File: tb/tb_de10_bus_resp_ctrl.sv
// Randomized bench for de10_bus_resp_ctrl; expectations come from a
// transaction-level model of region decode, ack latency and timeout.
module tb_de10_bus_resp_ctrl;

`ifdef DE10_BUS_TIMEOUT_EN
    localparam bit          TMO_EN = 1'b1;
    localparam int unsigned TB_TMO = 4;
`else
    localparam bit          TMO_EN = 1'b0;
    localparam int unsigned TB_TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        sdram_sel;
    logic        periph_sel;
    logic        tgt_we;
    logic [31:0] tgt_addr;
    logic [31:0] tgt_wdata;
    logic        sdram_ack;
    logic        periph_ack;
    logic [31:0] sdram_rdata;
    logic [31:0] periph_rdata;

    int checks = 0;
    int errors = 0;

    de10_bus_resp_ctrl #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TB_TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .cpu_err      (cpu_err),
        .sdram_sel    (sdram_sel),
        .periph_sel   (periph_sel),
        .tgt_we       (tgt_we),
        .tgt_addr     (tgt_addr),
        .tgt_wdata    (tgt_wdata),
        .sdram_ack    (sdram_ack),
        .periph_ack   (periph_ack),
        .sdram_rdata  (sdram_rdata),
        .periph_rdata (periph_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        sdram_rdata  = $urandom;
        periph_rdata = $urandom;
    endtask

    // One CPU transaction; delay is the sel cycle (1-based) in which the target acks.
    task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay,
                          input logic [31:0] rd, input logic other_ack);
        logic [9:0]  region;
        logic        is_sd;
        logic        is_pe;
        logic        tmo;
        logic [31:0] exp_rdata;
        int          n;
        region = addr[31:22];
        is_sd  = (region == 10'd0);
        is_pe  = (region == 10'd1);
        tmo    = (is_sd || is_pe) && TMO_EN && (delay > int'(TB_TMO));
        n      = tmo ? int'(TB_TMO) : delay;

        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        tick();
        checks++;
        if ({tgt_we, tgt_addr, tgt_wdata} !== {we, addr, wdata}) begin
            errors++;
            $display("FAIL %s latch: got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                     name, tgt_we, tgt_addr, tgt_wdata, we, addr, wdata);
        end
        if (!is_sd && !is_pe) begin
            checks++;
            if ({sdram_sel, periph_sel, cpu_ready, cpu_err} !== 4'b0011 || cpu_rdata !== 32'h0) begin
                errors++;
                $display("FAIL %s unmapped: got sel=%b%b rdy=%b err=%b rdata=%h want sel=00 rdy=1 err=1 rdata=0",
                         name, sdram_sel, periph_sel, cpu_ready, cpu_err, cpu_rdata);
            end
        end else begin
            for (int k = 1; k <= n; k++) begin
                checks++;
                if ({sdram_sel, periph_sel, cpu_ready} !== {is_sd, is_pe, 1'b0}) begin
                    errors++;
                    $display("FAIL %s wait%0d: got sel=%b%b rdy=%b want sel=%b%b rdy=0",
                             name, k, sdram_sel, periph_sel, cpu_ready, is_sd, is_pe);
                end
                if (k == delay) begin
                    if (is_sd) begin sdram_ack = 1'b1; sdram_rdata = rd; end
                    else begin periph_ack = 1'b1; periph_rdata = rd; end
                end
                if (other_ack && k == 1) begin
                    if (is_sd) periph_ack = 1'b1;
                    else sdram_ack = 1'b1;
                end
                tick();
                sdram_ack  = 1'b0;
                periph_ack = 1'b0;
            end
            exp_rdata = (tmo || we) ? 32'h0 : rd;
            checks++;
            if ({sdram_sel, periph_sel, cpu_ready, cpu_err} !== {3'b001, tmo} || cpu_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL %s resp: got sel=%b%b rdy=%b err=%b rdata=%h want sel=00 rdy=1 err=%b rdata=%h",
                         name, sdram_sel, periph_sel, cpu_ready, cpu_err, cpu_rdata, tmo, exp_rdata);
            end
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if ({sdram_sel, periph_sel, cpu_ready, cpu_err} !== 4'b0000) begin
            errors++;
            $display("FAIL %s idle: got sel=%b%b rdy=%b err=%b want all 0",
                     name, sdram_sel, periph_sel, cpu_ready, cpu_err);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({cpu_rdata, cpu_ready, cpu_err, sdram_sel, periph_sel, tgt_we, tgt_addr, tgt_wdata} !== '0) begin
            errors++;
            $display("FAIL %s: got rdata=%h rdy=%b err=%b sel=%b%b we=%b addr=%h wdata=%h want all 0",
                     name, cpu_rdata, cpu_ready, cpu_err, sdram_sel, periph_sel, tgt_we, tgt_addr, tgt_wdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        sdram_ack = 1'b0; periph_ack = 1'b0;
        sdram_rdata = '0; periph_rdata = '0;
        #2;
        check_all_zero("reset_async");
        tick();
        tick();
        check_all_zero("reset_held");
        rst_n = 1'b1;
        tick();
        check_all_zero("reset_release");
    endtask

    task automatic test_directed();
        do_txn("sdram_read", 1'b0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        do_txn("periph_write", 1'b1, 32'h0040_0004, 32'h1234_5678, 2, 32'hFFFF_0000, 1'b0);
        do_txn("unmapped", 1'b0, 32'h0080_0000, 32'h0, 1, 32'h0, 1'b0);
        do_txn("other_ack", 1'b0, 32'h0000_0200, 32'h0, 3, 32'hA5A5_5A5A, 1'b1);
        do_txn("min_latency", 1'b0, 32'h0040_0000, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_timeout();
        do_txn("ack_at_limit", 1'b0, 32'h0000_0010, 32'h0, int'(TB_TMO), 32'h1357_9BDF, 1'b0);
        do_txn("long_wait", 1'b0, 32'h0040_0020, 32'h0, 300, 32'h2468_ACE0, 1'b0);
    endtask

    task automatic test_random();
        logic [9:0]  region;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       region = 10'd0;
                1:       region = 10'd1;
                default: region = 10'($urandom_range(2, 1023));
            endcase
            addr = {region, 22'($urandom)};
            do_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), addr, $urandom,
                   $urandom_range(1, 6), $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    // Request held high across completion is re-accepted; accept-to-accept is 3 cycles.
    task automatic test_back_to_back();
        logic [3:0] got_sel;
        logic [3:0] got_rdy;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0300; cpu_wdata = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            got_sel[k] = sdram_sel;
            got_rdy[k] = cpu_ready;
            sdram_ack  = (k == 0);
            tick();
            sdram_ack = 1'b0;
        end
        checks++;
        if (got_sel !== 4'b1001 || got_rdy !== 4'b0010) begin
            errors++;
            $display("FAIL back_to_back: got sel=%b rdy=%b want sel=1001 rdy=0010", got_sel, got_rdy);
        end
        cpu_req   = 1'b0;
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        checks++;
        if (cpu_ready !== 1'b1 || sdram_sel !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back2: got rdy=%b sel=%b want rdy=1 sel=0", cpu_ready, sdram_sel);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0040_0010; cpu_wdata = 32'hCAFE_0001;
        tick();
        tick();
        checks++;
        if (periph_sel !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got periph_sel=%b want 1", periph_sel);
        end
        #2;
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_all_zero("reset_mid_async");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            periph_ack = 1'b1;
            tick();
            check_all_zero($sformatf("reset_mid_late_ack%0d", k));
        end
        periph_ack = 1'b0;
        do_txn("after_reset", 1'b0, 32'h0040_0008, 32'h0, 2, 32'h7777_1111, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/de10_bus_resp_ctrl.md
# de10_bus_resp_ctrl

Request/response controller between the CPU data port and the two DE10-Lite bus targets (SDRAM and peripheral block). It decodes each request into a one-hot target select, holds the select until the target acknowledges, and returns registered read data with a single-cycle ready pulse. Unmapped regions and, optionally, hung targets terminate with an error response, so the CPU never stalls forever.

## Interface
- ADDR_W, 32, address width; the region tag is addr[ADDR_W-1:ADDR_W-10]
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, wait cycles before a timeout abort (1..255)

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  registered read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle error pulse, coincident with cpu_ready
- sdram_sel / periph_sel  out  1  target select, held until that target acks
- tgt_we  out  1  latched cpu_we
- tgt_addr  out  ADDR_W  latched address
- tgt_wdata  out  DATA_W  latched write data
- sdram_ack / periph_ack  in  1  target completion strobe
- sdram_rdata / periph_rdata  in  DATA_W  target read data, valid with ack

## Operation
- Reset: state IDLE; all outputs 0; latched address, data and we are 0; timeout counter 0.
- States: IDLE, WAIT_SDRAM, WAIT_PERIPH, RESP, ERR.
- IDLE with cpu_req=1: latch we, addr and wdata. Tag 0 -> WAIT_SDRAM. Tag 1 -> WAIT_PERIPH. Any other tag -> ERR. IDLE with cpu_req=0: stay.
- WAIT_x: x_sel=1. On x_ack: capture x_rdata (0 on writes), go to RESP. The other target's ack is ignored.
- RESP: cpu_ready=1 and cpu_err=0 for one cycle, then IDLE.
- ERR: cpu_ready=1, cpu_err=1 and cpu_rdata=0 for one cycle, then IDLE.
- Select outputs are one-hot or zero and never both 1. They drop in the cycle after ack.
- cpu_req during WAIT/RESP/ERR is ignored. The CPU must hold req until ready; a request still asserted in IDLE is accepted as a new request.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. A target ack that arrives later is ignored.

## Timing
- Request accepted at edge N: sel is high from N+1.
- Ack sampled at edge M: sel falls and cpu_ready rises after M+1, lasting one cycle.
- Minimum latency (target acks in the first sel cycle): cpu_ready 2 cycles after acceptance.
- Unmapped address: cpu_ready/cpu_err 1 cycle after acceptance.
- Back-to-back throughput: one transaction every 3 cycles minimum (accept, wait, respond).

## Configuration
- DE10_BUS_TIMEOUT_EN defined:
  - The counter clears on entry to WAIT_x and increments each WAIT cycle without an ack.
  - When the count reaches TIMEOUT_CYCLES, sel drops and the state goes to ERR.
  - An ack in the same cycle as the limit wins, and the transfer completes normally.
- Not defined: no counter; WAIT_x holds indefinitely until ack.

## Structure
- Shared package de10_bus_pkg:
  - region tag constants TAG_SDRAM=10'h0 and TAG_PERIPH=10'h1
  - state encoding localparams
  - ADDR_W/DATA_W defaults
- Sub-module de10_bus_timeout_ctr: clear/enable inputs, expired output. Instantiated only under DE10_BUS_TIMEOUT_EN.

## Test plan
- Read 0x0000_0100, sdram_ack after 3 wait cycles with rdata 0xDEAD_BEEF -> sdram_sel high 3 cycles, then cpu_ready pulse with rdata 0xDEAD_BEEF and err=0.
- Write 0x0040_0004, data 0x1234_5678 -> periph_sel=1, tgt_we=1, tgt_wdata=0x1234_5678; periph_ack -> ready pulse with rdata 0.
- Access to 0x0080_0000 (tag 2) -> no select asserted; ready=1 and err=1 exactly 1 cycle after acceptance.
- During WAIT_SDRAM, pulse periph_ack -> ignored, state unchanged; then sdram_ack -> normal completion.
- With DE10_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> sel drops and ready+err pulse after 4 wait cycles; ack on cycle 4 -> normal completion instead.
- Assert rst_n=0 mid WAIT_PERIPH, then release and drive a late periph_ack -> outputs 0 throughout, state IDLE, no ready pulse.
